// File: rtl/piso_ctrl_pkg.sv
// ---------------------------------------------------------------
// piso_ctrl_pkg : shared FSM encoding and default bit period
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package piso_ctrl_pkg;

  localparam int unsigned DEFAULT_DIV = 50000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bit_tick_gen.sv
// ---------------------------------------------------------------
// bit_tick_gen : counts 0..DIV-1 while enabled, one-cycle tick at DIV-1
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module bit_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    tick    = en && (count_q == LAST);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_shift_ctrl.sv
// ---------------------------------------------------------------
// piso_shift_ctrl : parallel-in serial-out shifter with abortable frames
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module piso_shift_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = DEFAULT_DIV,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     abort,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         shreg_q
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  shreg_d;
  logic [IW-1:0]     bit_idx_q;
  logic [IW-1:0]     bit_idx_d;
  logic [WIDTH-1:0]  shreg_shifted;
  logic              out_bit;
  logic              div_clr;
  logic              tick;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign out_bit       = shreg_q[0];
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign out_bit       = shreg_q[WIDTH-1];
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end
  endgenerate

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (state_q == ST_SHIFT),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    div_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !abort) begin
          shreg_d = in_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_idx_d = '0;
        div_clr   = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            shreg_d   = shreg_shifted;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort only cancels an active frame; DONE always completes its pulse.
    if (abort && (state_q == ST_LOAD || state_q == ST_SHIFT)) begin
      state_d   = ST_IDLE;
      shreg_d   = '0;
      bit_idx_d = '0;
      div_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Outputs are masked by rst so they are quiet while reset is still held.
  assign busy      = !rst && (state_q == ST_LOAD || state_q == ST_SHIFT);
  assign ser_valid = !rst && (state_q == ST_SHIFT);
  assign ser_out   = ser_valid && out_bit;
  assign done      = !rst && (state_q == ST_DONE);
  assign in_ready  = !rst && (state_q == ST_IDLE) && !abort;
  assign bit_idx   = bit_idx_q;

endmodule

`default_nettype wire

// File: doc/piso_shift_ctrl.md
PISO_SHIFT_CTRL -- requirements
Module: piso_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, shall set the parallel word width in bits (>=2).
REQ-002 Parameter DIV, default 50000000, shall set the clk cycles each serial bit is held (>=1).
REQ-003 Parameter LSB_FIRST, default 0, shall select bit order: 0 = MSB first, 1 = LSB first.
REQ-004 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  shall be a synchronous, active-high reset.
REQ-006 in_valid  input  1  shall indicate that in_data holds a word to serialize.
REQ-007 in_data  input  WIDTH  shall be the parallel word, sampled only on acceptance.
REQ-008 in_ready  output  1  shall indicate the block can accept a word this cycle.
REQ-009 abort  input  1  shall cancel any frame in progress.
REQ-010 ser_out  output  1  shall be the current serial bit.
REQ-011 ser_valid  output  1  shall be high in every cycle in which ser_out carries a frame bit.
REQ-012 bit_idx  output  clog2(WIDTH)  shall give the index (0..WIDTH-1) of the bit currently on ser_out.
REQ-013 busy  output  1  shall be high in states LOAD and SHIFT.
REQ-014 done  output  1  shall pulse high for exactly one cycle when a frame completes without abort.
REQ-015 shreg_q  output  WIDTH  shall expose the internal shift register (LED mirror).

Function
REQ-016 FSM states shall be IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE: in_ready = ~abort; on in_valid & in_ready, in_data shall be captured into shreg and the next state shall be LOAD.
REQ-018 LOAD: lasts one cycle; clears the bit counter and the divider count; next state SHIFT.
REQ-019 SHIFT: ser_valid = 1; ser_out = shreg[WIDTH-1] (LSB_FIRST=0) or shreg[0] (LSB_FIRST=1).
REQ-020 SHIFT: the divider counts 0..DIV-1; the cycle with count DIV-1 is the bit tick.
REQ-021 On a tick with bit_idx < WIDTH-1: shreg shifts one position toward the output end with zero fill, bit_idx increments, count returns to 0.
REQ-022 On a tick with bit_idx = WIDTH-1, the next state shall be DONE; shreg shall not shift.
REQ-023 DONE: done = 1, ser_valid = 0, in_ready = 0; next state IDLE.
REQ-024 Latency: for a word accepted at edge N, the first bit shall be on ser_out from cycle N+2; done shall be high in cycle N+2+WIDTH*DIV.
REQ-025 Each bit shall be stable on ser_out for exactly DIV consecutive cycles; DIV=1 shall give one bit per cycle.
REQ-026 abort in LOAD or SHIFT shall force IDLE on the next edge, clear shreg and bit_idx, and produce no done pulse.
REQ-027 abort in DONE shall be ignored (done still pulses); abort in IDLE shall only block acceptance.
REQ-028 in_valid outside IDLE shall be ignored; the next word shall be acceptable in the first IDLE cycle after DONE.
REQ-029 The divider counter shall be wide enough for DIV-1 and shall never wrap past DIV-1.
REQ-030 ser_out shall be 0 whenever ser_valid is 0.

Reset
REQ-031 On rst, the next state shall be IDLE with shreg = 0, bit_idx = 0, divider count = 0.
REQ-032 During and immediately after rst: done = 0, busy = 0, ser_valid = 0, ser_out = 0; in_ready becomes 1 in the first cycle after rst deasserts.
REQ-033 rst mid-frame shall abandon the frame with no done pulse; rst shall take priority over abort and in_valid.

Structure
REQ-034 The state encoding enum and the default DIV constant shall live in the shared package piso_ctrl_pkg.
REQ-035 The divider shall be the sub-module bit_tick_gen: clk, rst, clr, en, and a single-cycle tick output, parameterized by DIV.
REQ-036 The FSM, bit counter and shift register shall stay in piso_shift_ctrl.

Verification (WIDTH=8, DIV=4, LSB_FIRST=0 unless stated)
REQ-037 Accept in_data=8'hA5 at edge N -> ser_out = 1,0,1,0,0,1,0,1, each bit held 4 cycles from cycle N+2; done in cycle N+34 only.
REQ-038 LSB_FIRST=1, DIV=1, in_data=8'h01 -> ser_out = 1 then seven 0s on consecutive cycles; done in cycle N+10.
REQ-039 abort asserted while bit_idx=3 -> IDLE next cycle, shreg_q=0, no done pulse, in_ready=1 the following cycle.
REQ-040 in_valid held high with 8'hFF then 8'h00 -> second word accepted in the first IDLE cycle after done; no cycles where in_ready=1 while busy=1.
REQ-041 rst pulsed at bit_idx=5 -> all outputs reset the next cycle, no done pulse; a new 8'h3C frame then completes normally.
REQ-042 abort and in_valid both high in IDLE -> in_ready=0, no word accepted, state stays IDLE.
